// File: rtl/sync_serial_rx_if.sv
// Receive-side bundle of sync_serial_rx: FWFT byte stream plus status/control.
// master = receiver, slave = consumer.
interface sync_serial_rx_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          frame_err;
   logic          overrun;
   logic          clr_overrun;
   logic [CW-1:0] fifo_count;

   modport master (
      output rx_data, rx_valid, frame_err, overrun, fifo_count,
      input  rx_ready, clr_overrun
   );

   modport slave (
      input  rx_data, rx_valid, frame_err, overrun, fifo_count,
      output rx_ready, clr_overrun
   );
endinterface

// File: rtl/sync_serial_rx.sv
// Bit-banged serial receiver: start(1)+8 LSB-first+stop(0) framed into a FWFT FIFO.
// Byte visible SYNC_STAGES+2 clk after the stop strobe rises; a full FIFO drops bytes and sets overrun.
module sync_serial_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 65535,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ser_data_i,
   input  logic               ser_clk_i,
   sync_serial_rx_if.master   rx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

   logic [SYNC_STAGES-1:0] dsync_q, csync_q;
   logic                   cprev_q;
   logic                   sample, ser_rise;

   state_t        state_q, state_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_d, frame_err_q;
   logic          push_req;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count;
   logic          empty, full, push, pop;
   logic          overrun_q, overrun_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dsync_q <= '0;
         csync_q <= '0;
         cprev_q <= 1'b0;
      end else begin
         dsync_q <= {dsync_q[SYNC_STAGES-2:0], ser_data_i};
         csync_q <= {csync_q[SYNC_STAGES-2:0], ser_clk_i};
         cprev_q <= csync_q[SYNC_STAGES-1];
      end
   end

   assign sample   = dsync_q[SYNC_STAGES-1];
   assign ser_rise = csync_q[SYNC_STAGES-1] & ~cprev_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         bitcnt_q    <= '0;
         shift_q     <= '0;
         tmo_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         shift_q     <= shift_d;
         tmo_q       <= tmo_d;
         frame_err_q <= err_d;
      end
   end

   // Strobe edges take priority over an expiring timeout in the same cycle.
   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      tmo_d    = '0;
      err_d    = 1'b0;
      push_req = 1'b0;
      case (state_q)
         IDLE: begin
            if (ser_rise && sample) begin
               state_d  = DATA;
               bitcnt_d = '0;
               shift_d  = '0;
            end
         end
         DATA: begin
            if (ser_rise) begin
               shift_d[bitcnt_q] = sample;
               bitcnt_d          = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = STOP;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         STOP: begin
            if (ser_rise) begin
               push_req = ~sample;
               err_d    = sample;
               state_d  = IDLE;
            end else if (tmo_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign count = wr_ptr_q - rd_ptr_q;
   assign empty = (count == '0);
   assign full  = (count == CW'(FIFO_DEPTH));
   assign pop   = ~empty & rx.rx_ready;
   // A pop in the same cycle frees the slot for the incoming byte.
   assign push      = push_req & (~full | pop);
   assign overrun_d = (push_req & full & ~pop) | (overrun_q & ~rx.clr_overrun);

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         overrun_q <= overrun_d;
      end
   end

   assign rx.rx_data    = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
   assign rx.rx_valid   = ~empty;
   assign rx.frame_err  = frame_err_q;
   assign rx.overrun    = overrun_q;
   assign rx.fifo_count = count;
endmodule

// File: doc/sync_serial_rx.md
Name: sync_serial_rx

Overview:
- Host-side receiver for the computer's bit-banged serial output link: UART_tx carries data and UART_clk carries the strobe, both driven by software through scratchpad bits 7 and 6.
- Synchronises both lines into the receiver clock domain, samples data on each rising edge of the serial clock, frames 8-bit bytes LSB-first, and buffers them in a small FIFO with a valid/ready read handshake.
- Used by the FPGA top level and the bench to capture program output.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on ser_data and ser_clk (minimum 2).
- TIMEOUT, 65535, clk cycles allowed between serial clock edges inside a frame before the frame is aborted.
- FIFO_DEPTH, 4, byte buffer entries (power of two, minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- ser_data  in  1  serial data (UART_tx), asynchronous to clk.
- ser_clk  in  1  serial strobe (UART_clk), asynchronous to clk.
- rx_data  out  8  FIFO head byte; valid only while rx_valid=1.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts the head byte when rx_valid and rx_ready are both 1.
- frame_err  out  1  one-cycle pulse when a frame is rejected.
- overrun  out  1  sticky; set when a good byte arrives while the FIFO is full.
- clr_overrun  in  1  synchronous clear of overrun.
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; synchronisers cleared to 0; bit counter, timeout counter and FIFO pointers cleared. Outputs reset to rx_valid=0, rx_data=0, frame_err=0, overrun=0, fifo_count=0.
- Synchronisation and sampling:
  - ser_clk and ser_data each pass through SYNC_STAGES flip-flops.
  - A rising edge is the synchronised ser_clk at 1 with its previous value at 0. Falling edges are ignored.
  - On a rising edge, the synchronised ser_data is sampled in the same cycle as the edge is detected.
- Frame format: 1 start bit, then 8 data bits LSB first, then 1 stop bit. The start bit must be 1 and the stop bit must be 0, because the line idles at 0 after reset.
- FSM:
  - IDLE: on an edge, if sample=1 go to DATA with bitcnt=0; if sample=0 stay in IDLE and assert no error (this resynchronises on stray clocks).
  - DATA: on each edge, shift the sample in at shift[bitcnt] and increment bitcnt. After the 8th bit go to STOP.
  - STOP: on an edge with sample=0, the byte is good and is pushed into the FIFO; go to IDLE. On an edge with sample=1, pulse frame_err, drop the byte and go to IDLE.
- Timeout:
  - In DATA or STOP, a counter increments every clk and resets on each edge.
  - When it reaches TIMEOUT: pulse frame_err, go to IDLE, discard partial data.
  - The counter is held at 0 in IDLE.
- Latency: a good byte is written on the cycle its stop edge is detected. rx_valid rises on the following clk cycle. End to end, that is SYNC_STAGES+2 clk cycles after ser_clk rises.
- FIFO:
  - First-word-fall-through: rx_data always shows the head entry.
  - A read occurs when rx_valid and rx_ready are both 1; the pointer advances on that clk edge.
  - Simultaneous push and pop on a full FIFO: the pop frees the slot, the push succeeds, count is unchanged and overrun is not set.
  - Push while full with no pop: the byte is dropped, FIFO contents are unchanged, and overrun is set.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH, with one extra bit to distinguish full from empty.
- overrun: clr_overrun clears it. If set and clear happen in the same cycle, set wins.
- Reset mid-frame: the partial frame and the FIFO contents are lost. No frame_err pulse.

Test Plan:
- Byte 0xA5 sent as start=1, bits 1,0,1,0,0,1,0,1, stop=0, ser_clk period 20 clk -> rx_valid=1 with rx_data=0xA5 exactly 4 cycles after the stop-bit ser_clk rise; frame_err stays 0.
- Stop bit sent as 1 -> one frame_err pulse, fifo_count stays 0. An immediately following valid frame 0x3C is received correctly.
- Frame stalled after 3 data bits with TIMEOUT=100 -> frame_err pulses at cycle 100 after the last edge. The next frame 0x81 is received as 0x81.
- 5 bytes 0x01..0x05 sent with rx_ready=0 and FIFO_DEPTH=4 -> fifo_count=4 and overrun=1. Draining yields 0x01..0x04 in order. clr_overrun then clears the flag.
- FIFO full with rx_ready=1 pulsed on the same cycle as a new byte 0x77 is pushed -> count stays 4, overrun=0, 0x77 is last out.
- Leading ser_clk edges with data=0 (3 stray edges) before frame 0xFF -> no frame_err; 0xFF received.
- rst asserted mid-frame -> all outputs go to reset values immediately, without waiting for a clk edge.
